// File: rtl/coin_pkg.sv
// Shared types and constants for the coin detector: coin codes, the
// per-channel state encoding and the dwell-counter width helper.
package coin_pkg;

  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NONE   = 2'b00;
  localparam coin_code_t COIN_NICKEL = 2'b01;
  localparam coin_code_t COIN_DIME   = 2'b10;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_QUAL = 2'd1,
    CH_HELD = 2'd2,
    CH_JAM  = 2'd3
  } ch_state_t;

  // Width needed to count up to and including jam_cycles.
  function automatic int occ_width(input int jam_cycles);
    return $clog2(jam_cycles + 1);
  endfunction

endpackage

// File: rtl/coin_detector_if.sv
// Sensor/jam-clear inputs and coin-code/status outputs of the detector.
// master drives the sensors (the environment), slave is the detector.
interface coin_detector_if;
  import coin_pkg::*;

  logic       nickel_sense;
  logic       dime_sense;
  logic       jam_clr;
  coin_code_t X;
  logic       coin_reject;
  logic       jam;
  logic [7:0] coin_count;

  modport master (
    output nickel_sense, dime_sense, jam_clr,
    input  X, coin_reject, jam, coin_count
  );

  modport slave (
    input  nickel_sense, dime_sense, jam_clr,
    output X, coin_reject, jam, coin_count
  );

endinterface

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, IDLE/QUAL/HELD/JAM FSM, a
// shared high/low run counter and a dwell counter for jam detection.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic sense,
  output logic strobe,
  output logic in_jam
);

  localparam int              OCC_W   = occ_width(JAM_CYCLES);
  localparam logic [7:0]      DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_LIM = OCC_W'(JAM_CYCLES);

  logic [1:0]       sync;   // sync[1] is the metastability-safe copy
  ch_state_t        state;
  logic [7:0]       cnt;    // consecutive highs in QUAL, consecutive lows in HELD/JAM
  logic [OCC_W-1:0] occ;    // cycles spent in QUAL+HELD, including the current one
  logic             s;

  assign s = sync[1];

  // The qualify strobe is decoded from state so the downstream X register
  // can fire on the same edge the channel enters HELD.
  assign strobe = (state == CH_QUAL) && s && (cnt == DB_LAST);
  assign in_jam = (state == CH_JAM);

  // Synchronizer plus channel FSM with its run and dwell counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= 2'b00;
      state <= CH_IDLE;
      cnt   <= 8'd0;
      occ   <= '0;
    end else begin
      sync <= {sync[0], sense};
      unique case (state)
        CH_IDLE: begin
          if (s) begin
            state <= CH_QUAL;
            cnt   <= 8'd1;
            occ   <= OCC_W'(1);
          end
        end
        CH_QUAL: begin
          if (!s) begin
            // Glitch: too short to be a coin.
            state <= CH_IDLE;
            cnt   <= 8'd0;
            occ   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= CH_HELD;
            cnt   <= 8'd0;
            occ   <= occ + OCC_W'(1);
          end else begin
            cnt <= cnt + 8'd1;
            occ <= occ + OCC_W'(1);
          end
        end
        CH_HELD: begin
          if (!s && cnt == DB_LAST) begin
            // Clean release wins over a jam decision on the same edge.
            state <= CH_IDLE;
            cnt   <= 8'd0;
            occ   <= '0;
          end else if (occ == OCC_LIM) begin
            state <= CH_JAM;
            cnt   <= 8'd0;
            occ   <= '0;
          end else begin
            cnt <= s ? 8'd0 : cnt + 8'd1;
            occ <= occ + OCC_W'(1);
          end
        end
        CH_JAM: begin
          if (s) begin
            cnt <= 8'd0;
          end else if (cnt == DB_LAST) begin
            state <= CH_IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= CH_IDLE;
          cnt   <= 8'd0;
          occ   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/coin_detector.sv
// Coin detector top: two debounced channels, arbitration into a one-cycle
// coin code, accepted-coin counter and a sticky jam flag.
module coin_detector
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic            clock,
  input  logic            reset,
  coin_detector_if.slave  bus
);

  logic       n_stb, d_stb;
  logic       n_jam, d_jam;
  coin_code_t x_q;
  logic       reject_q;
  logic       jam_q;
  logic [7:0] count_q;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_nickel (
    .clock  (clock),
    .reset  (reset),
    .sense  (bus.nickel_sense),
    .strobe (n_stb),
    .in_jam (n_jam)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_dime (
    .clock  (clock),
    .reset  (reset),
    .sense  (bus.dime_sense),
    .strobe (d_stb),
    .in_jam (d_jam)
  );

  // Arbitrate strobes into a single-cycle coin code or a reject pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q      <= COIN_NONE;
      reject_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      x_q      <= COIN_NONE;
      reject_q <= 1'b0;
      unique case ({d_stb, n_stb})
        2'b01: begin
          x_q     <= COIN_NICKEL;
          count_q <= count_q + 8'd1;
        end
        2'b10: begin
          x_q     <= COIN_DIME;
          count_q <= count_q + 8'd1;
        end
        2'b11:   reject_q <= 1'b1;  // ambiguous coin, count untouched
        default: ;
      endcase
    end
  end

  // Sticky jam: any channel in JAM keeps it set; clear only once both are out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jam_q <= 1'b0;
    end else if (n_jam || d_jam) begin
      jam_q <= 1'b1;
    end else if (bus.jam_clr) begin
      jam_q <= 1'b0;
    end
  end

  assign bus.X           = x_q;
  assign bus.coin_reject = reject_q;
  assign bus.jam         = jam_q;
  assign bus.coin_count  = count_q;

endmodule

// File: doc/coin_detector.md
COIN_DETECTOR -- requirements
Module: coin_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive synchronized-high (or low) cycles to qualify a press (or release); legal range 2..255.
REQ-002 Parameter JAM_CYCLES, default 1000, cycles a qualified sensor may stay high before it is declared jammed; SHALL exceed DEBOUNCE_CYCLES.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 nickel_sense  input  1  raw asynchronous nickel sensor, high while a coin is present.
REQ-006 dime_sense  input  1  raw asynchronous dime sensor, high while a coin is present.
REQ-007 jam_clr  input  1  synchronous one-cycle request to clear the jam flag.
REQ-008 X  output  2  coin code to the downstream vending FSM: 2'b01 nickel, 2'b10 dime, 2'b00 none; 2'b11 never driven.
REQ-009 coin_reject  output  1  one-cycle pulse when a coin is discarded.
REQ-010 jam  output  1  sticky jam indication.
REQ-011 coin_count  output  8  accepted-coin counter.

Function
REQ-012 Each sense input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL run a 4-state FSM: IDLE, QUAL, HELD, JAM.
REQ-014 IDLE->QUAL when the synchronized input is 1; the qualification counter is loaded with 1.
REQ-015 In QUAL, a synchronized 1 increments the counter. At DEBOUNCE_CYCLES the channel enters HELD and raises its qualify strobe for one cycle.
REQ-016 In QUAL, a synchronized 0 returns the channel to IDLE with the counter cleared; no strobe (glitch rejection).
REQ-017 In HELD, DEBOUNCE_CYCLES consecutive synchronized 0s return the channel to IDLE. Any 1 restarts the low count.
REQ-018 HELD->JAM when the channel has been in QUAL+HELD for JAM_CYCLES cycles. JAM->IDLE after DEBOUNCE_CYCLES consecutive synchronized 0s.
REQ-019 X SHALL be registered and asserted for exactly one cycle per accepted coin.
REQ-020 Latency: raw input first sampled high at edge E0 and held -> X valid in the cycle after edge E0+1+DEBOUNCE_CYCLES. With the default, X is valid after edge E0+5.
REQ-021 If exactly one channel strobes in a cycle, X takes that channel's code and coin_count increments by 1.
REQ-022 coin_count wraps from 255 to 0.
REQ-023 If both channels strobe in the same cycle, X stays 2'b00, coin_reject pulses for one cycle, and coin_count is unchanged.
REQ-024 While a channel is in JAM, its strobe is suppressed. The other channel continues to operate normally.
REQ-025 jam SHALL set in the cycle after either channel enters JAM.
REQ-026 jam SHALL clear only on reset, or on jam_clr when neither channel is in JAM. jam_clr while a channel is still in JAM is ignored.
REQ-027 Set has priority when jam_clr coincides with a new JAM entry.

Reset
REQ-028 On reset, synchronizers are 0, both FSMs are in IDLE, and all counters are 0.
REQ-029 Output reset values: X=2'b00, coin_reject=0, jam=0, coin_count=8'd0.
REQ-030 Reset asserted mid-QUAL or mid-HELD SHALL produce no X pulse. After release, a sensor still held high SHALL be re-qualified from IDLE and counted once.

Structure
REQ-031 Shared package coin_pkg SHALL hold:
- coin code constants COIN_NONE, COIN_NICKEL, COIN_DIME;
- the channel state enum;
- the counter-width function (clog2 of JAM_CYCLES+1).
REQ-032 One sub-module, coin_debounce, SHALL implement the per-channel synchronizer, FSM and counters. It is instantiated twice.
REQ-033 The arbitration, coin_count and jam logic SHALL reside in coin_detector.

Verification
REQ-034 nickel_sense high for 10 cycles (default parameters) -> X=2'b01 for one cycle at E0+5; coin_count=1; no further pulse.
REQ-035 dime_sense high for 2 cycles, then low -> X stays 2'b00 throughout; coin_count unchanged.
REQ-036 Both sense inputs rise at the same edge and are held 10 cycles -> coin_reject=1 for one cycle; X=2'b00; coin_count unchanged.
REQ-037 With JAM_CYCLES=20, dime_sense held high for 30 cycles:
- one dime pulse;
- jam=1 from cycle 21 onward;
- jam_clr while the input is high has no effect;
- after 4 low cycles, jam_clr -> jam=0.
REQ-038 256 nickels -> coin_count wraps to 0. Reset asserted 2 cycles into a press -> all outputs return to reset values and no X pulse.
